// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction-memory loader
//
// Purpose: loader state encoding, the ASCII bytes the loader recognises, and
//          the default instruction width.
// Ports:   none (package).
// Config:  INSTR_LOADER_CRLF_EN is consumed by instr_mem_loader, not here.

package instr_loader_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [7:0] CHAR_0   = 8'h30;
  localparam logic [7:0] CHAR_1   = 8'h31;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_EOT = 8'h04;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/ascii_bit_decoder.sv
// rtl/ascii_bit_decoder.sv - combinational classification of one program-image byte
//
// Purpose: sorts an incoming ASCII byte into the classes the loader FSM acts on.
// Ports:
//   in_data  in  8  byte under inspection
//   is_bit   out 1  byte is '0' or '1'
//   bit_val  out 1  value of the bit character (valid when is_bit)
//   is_lf    out 1  line feed
//   is_cr    out 1  carriage return (legality is decided by the loader)
//   is_eot   out 1  end-of-transmission
//   is_bad   out 1  none of the above
// Config:  none.

import instr_loader_pkg::*;

module ascii_bit_decoder (
  input  logic [7:0] in_data,
  output logic       is_bit,
  output logic       bit_val,
  output logic       is_lf,
  output logic       is_cr,
  output logic       is_eot,
  output logic       is_bad
);

  always_comb begin
    is_bit  = (in_data == CHAR_0) || (in_data == CHAR_1);
    bit_val = (in_data == CHAR_1);
    is_lf   = (in_data == CHAR_LF);
    is_cr   = (in_data == CHAR_CR);
    is_eot  = (in_data == CHAR_EOT);
    is_bad  = !(is_bit || is_lf || is_cr || is_eot);
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - assembles ASCII binary lines into instruction-memory writes
//
// Purpose: consumes a newline-terminated stream of XLEN-character '0'/'1' lines
//          (MSB first) and writes each word to consecutive addresses from 0.
// Ports:
//   clk         in  1         rising-edge clock
//   rst_n       in  1         asynchronous active-low reset
//   start       in  1         begin a load at address 0 (ignored while busy)
//   in_valid    in  1         byte-source valid
//   in_data     in  8         ASCII byte
//   in_ready    out 1         byte accepted when in_valid && in_ready
//   wr_en       out 1         memory write strobe, one cycle per word
//   wr_addr     out ADDR_W    next word address to be written
//   wr_data     out XLEN      last assembled word
//   busy        out 1         load in progress
//   done        out 1         load finished cleanly (sticky until start/reset)
//   err         out 1         malformed stream (sticky until start/reset)
//   word_count  out ADDR_W+1  words written in this load
// Config: define INSTR_LOADER_CRLF_EN to accept CR directly after a full line.

import instr_loader_pkg::*;

module instr_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]   wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int              CNT_W    = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(XLEN);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [XLEN-1:0]     shift_q, shift_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [ADDR_W:0]     wcnt_q, wcnt_d;

  logic is_bit, bit_val, is_lf, is_cr, is_eot, is_bad;
  logic line_full, line_empty, cr_ok;

  ascii_bit_decoder u_dec (
    .in_data (in_data),
    .is_bit  (is_bit),
    .bit_val (bit_val),
    .is_lf   (is_lf),
    .is_cr   (is_cr),
    .is_eot  (is_eot),
    .is_bad  (is_bad)
  );

  assign line_full  = (bit_cnt_q == FULL_CNT);
  assign line_empty = (bit_cnt_q == '0);

`ifdef INSTR_LOADER_CRLF_EN
  // CR is only tolerated as the first half of a CRLF after a complete line.
  assign cr_ok = is_cr && line_full;
`else
  assign cr_ok = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wdata_d   = wdata_q;
    wcnt_d    = wcnt_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = SHIFT;
          addr_d    = '0;
          bit_cnt_d = '0;
          wcnt_d    = '0;
        end
      end

      SHIFT: begin
        if (in_valid) begin
          if (is_bit) begin
            if (line_full) begin
              state_d = ERR;
            end else begin
              shift_d   = {shift_q[XLEN-2:0], bit_val};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else if (is_lf) begin
            if (line_full) begin
              // Latch the word here so wr_data stays stable after the write.
              state_d = WRITE;
              wdata_d = shift_q;
            end else if (!line_empty) begin
              state_d = ERR;
            end
          end else if (is_eot) begin
            state_d = line_empty ? DONE : ERR;
          end else if (is_cr) begin
            if (!cr_ok) state_d = ERR;
          end else if (is_bad) begin
            state_d = ERR;
          end
        end
      end

      WRITE: begin
        addr_d    = addr_q + ADDR_W'(1);
        wcnt_d    = wcnt_q + (ADDR_W+1)'(1);
        bit_cnt_d = '0;
        // The last address of the memory ends the load; the address wraps to 0.
        state_d   = (&addr_q) ? DONE : SHIFT;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wdata_q   <= '0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wdata_q   <= wdata_d;
      wcnt_q    <= wcnt_d;
    end
  end

  assign in_ready   = (state_q == SHIFT);
  assign wr_en      = (state_q == WRITE);
  assign busy       = (state_q == SHIFT) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign wr_addr    = addr_q;
  assign wr_data    = wdata_q;
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader with a byte-level reference model

import instr_loader_pkg::*;

module tb_instr_mem_loader;

  localparam int ADDR_W = 2;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  stim_q[$];
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          exp_end;
  int          exp_consumed;
  int          exp_nwr;
  logic [31:0] last_wr = '0;
  bit          crlf_en;
  bit          stall_en = 1'b0;

  instr_mem_loader #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe is matched against the next expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %0d data 0x%08h required=no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(wr_data), 64'(mon_e.data));
      end
    end
  end

  // Reference model: walks the byte stream by the loader's line rules.
  // exp_end: 1 = done, 2 = err.
  task automatic model();
    int          cnt  = 0;
    int          addr = 0;
    logic [31:0] word = '0;
    wr_t         w;
    exp_end      = 0;
    exp_consumed = 0;
    exp_nwr      = 0;
    foreach (stim_q[i]) begin
      logic [7:0] b;
      b = stim_q[i];
      exp_consumed++;
      if (b == CHAR_0 || b == CHAR_1) begin
        if (cnt == XLEN) begin exp_end = 2; break; end
        word = word * 2 + ((b == CHAR_1) ? 32'd1 : 32'd0);
        cnt++;
      end else if (b == CHAR_LF) begin
        if (cnt == XLEN) begin
          w.addr = addr % DEPTH;
          w.data = word;
          exp_q.push_back(w);
          last_wr = word;
          addr++;
          exp_nwr++;
          cnt  = 0;
          word = '0;
          if (addr == DEPTH) begin exp_end = 1; break; end
        end else if (cnt != 0) begin
          exp_end = 2; break;
        end
      end else if (b == CHAR_CR && crlf_en && cnt == XLEN) begin
        // discarded
      end else if (b == CHAR_EOT && cnt == 0) begin
        exp_end = 1; break;
      end else begin
        exp_end = 2; break;
      end
    end
  endtask

  task automatic add_word(input logic [31:0] w, input bit cr);
    for (int i = 31; i >= 0; i--) stim_q.push_back(w[i] ? CHAR_1 : CHAR_0);
    if (cr) stim_q.push_back(CHAR_CR);
    stim_q.push_back(CHAR_LF);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents bytes in order, holding each until handshaken; stops at done/err.
  task automatic drive(input int limit, output int sent);
    int guard = 0;
    sent = 0;
    while (sent < stim_q.size() && sent < limit) begin
      @(negedge clk);
      if (done || err) break;
      guard++;
      if (guard > 5000) begin
        checks++;
        failures++;
        $display("FAIL drive_timeout actual=%0d bytes sent required=%0d", sent, stim_q.size());
        break;
      end
      in_data  = stim_q[sent];
      in_valid = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (in_valid && in_ready) sent++;
    end
    if (!(done || err)) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_term();
    int n = 0;
    while (!(done || err) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_load(input string name);
    int sent;
    model();
    pulse_start();
    chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
    chk({name, "_flags_cleared"}, 64'({done, err}), 64'd0);
    drive(1 << 30, sent);
    wait_term();
    chk({name, "_consumed"}, 64'(sent), 64'(exp_consumed));
    chk({name, "_done"}, 64'(done), 64'(exp_end == 1));
    chk({name, "_err"}, 64'(err), 64'(exp_end == 2));
    chk({name, "_word_count"}, 64'(word_count), 64'(exp_nwr));
    chk({name, "_wr_addr_next"}, 64'(wr_addr), 64'(exp_nwr % DEPTH));
    chk({name, "_wr_data_hold"}, 64'(wr_data), 64'(last_wr));
    chk({name, "_idle_io"}, 64'({in_ready, busy, wr_en}), 64'd0);
    chk({name, "_writes_seen"}, 64'(exp_q.size()), 64'd0);
    stim_q.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctrl"}, 64'({in_ready, wr_en, busy, done, err}), 64'd0);
    chk({name, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({name, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({name, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
`ifdef INSTR_LOADER_CRLF_EN
    crlf_en = 1'b1;
`else
    crlf_en = 1'b0;
`endif
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Two directed lines then EOT.
    add_word(32'h0000_0001, 1'b0);
    add_word(32'h8000_0000, 1'b0);
    stim_q.push_back(CHAR_EOT);
    run_load("two_lines");

    // 31-character line.
    add_word(32'h1234_5678, 1'b0);
    void'(stim_q.pop_front());
    stim_q.push_back(CHAR_EOT);
    run_load("short_line");

    // Recovery from err: fresh load at address 0.
    add_word(32'hA5A5_0F0F, 1'b0);
    stim_q.push_back(CHAR_EOT);
    run_load("after_err");

    // Illegal character mid-line.
    add_word(32'hFFFF_0000, 1'b0);
    stim_q[10] = 8'h78;
    stim_q.push_back(CHAR_EOT);
    run_load("bad_char");

    // Memory full: 5 lines into a 4-word memory.
    for (int i = 0; i < 5; i++) add_word($urandom, 1'b0);
    run_load("mem_full");

    // Source stalls.
    stall_en = 1'b1;
    add_word(32'hDEAD_BEEF, 1'b0);
    stim_q.push_back(CHAR_EOT);
    run_load("stall_deadbeef");

    // CRLF line ending.
    add_word(32'h0BAD_F00D, 1'b1);
    stim_q.push_back(CHAR_EOT);
    run_load("crlf");

    // Randomised streams with blank lines and occasional corrupted bytes.
    for (int t = 0; t < 10; t++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 3) == 0) stim_q.push_back(CHAR_LF);
        add_word($urandom, crlf_en && ($urandom_range(0, 1) == 1));
      end
      if (stim_q.size() > 0 && $urandom_range(0, 2) == 0)
        stim_q[$urandom_range(0, stim_q.size() - 1)] = 8'($urandom_range(0, 255));
      stim_q.push_back(CHAR_EOT);
      run_load("random");
    end

    // Reset mid-line: immediate abort with no write.
    add_word($urandom, 1'b0);
    pulse_start();
    drive(10, sent);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midline_reset");
    chk("midline_reset_no_write", 64'(exp_q.size()), 64'd0);
    last_wr = '0;
    stim_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    add_word(32'h1357_9BDF, 1'b0);
    stim_q.push_back(CHAR_EOT);
    run_load("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writer side of the instruction-memory path: accepts the program image as an ASCII byte stream (one line of 32 '0'/'1' characters, MSB first, per instruction, newline-terminated) and writes each assembled 32-bit word into instruction memory at consecutive word addresses starting from 0. It sits between the testbench or host byte source and the instruction memory write port. After loading, instruction fetch reads the program back by PC index.

## Interface
- ADDR_W, 10, instruction-memory word-address width; depth = 2**ADDR_W
- XLEN, 32, instruction width; each line must carry exactly XLEN bit characters
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load at address 0
- in_valid  in  1  byte-source valid
- in_data  in  8  ASCII byte
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid && in_ready
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word address for the write
- wr_data  out  XLEN  assembled instruction
- busy  out  1  load in progress
- done  out  1  load finished cleanly; sticky until the next start or reset
- err  out  1  malformed stream; sticky until the next start or reset
- word_count  out  ADDR_W+1  number of words written in this load

## Operation
- States: IDLE, SHIFT, WRITE, DONE, ERR.
- IDLE: in_ready=0. start -> SHIFT, which clears the address, bit count, word_count, done and err.
- SHIFT: in_ready=1. On each accepted byte:
  - '0' (0x30) or '1' (0x31): shift the bit into the shift register at the LSB (first character becomes bit XLEN-1), then increment bit_cnt.
  - A bit character arriving when bit_cnt==XLEN -> ERR.
  - 0x0A with bit_cnt==XLEN -> WRITE.
  - 0x0A with bit_cnt==0 (blank line) is ignored.
  - 0x0A with any other bit_cnt -> ERR.
  - 0x04 (EOT) with bit_cnt==0 -> DONE. 0x04 with a partial line -> ERR.
  - Any other byte -> ERR.
- WRITE: one cycle, in_ready=0.
  - wr_en=1, wr_data=shift register, wr_addr=current address.
  - Next cycle: address+1, word_count+1, bit_cnt cleared.
  - If the written address was 2**ADDR_W-1 -> DONE (memory full). Otherwise -> SHIFT.
- DONE / ERR: in_ready=0. start -> SHIFT (a fresh load).
- start in SHIFT or WRITE is ignored.
- wr_addr always equals the next address to be written; wr_data holds the last assembled word when wr_en=0.

## Timing
- Reset values:
  - state IDLE; in_ready, wr_en, busy, done and err all 0.
  - wr_addr, wr_data and word_count 0.
- Reset asserted mid-load aborts immediately with no partial write. Words already written remain in memory.
- Latency:
  - wr_en asserts in the cycle after the newline handshake.
  - in_ready returns 1 in the cycle after wr_en.
- Throughput: one byte per cycle; XLEN+1 data cycles plus one write cycle per word.
- busy=1 in SHIFT and WRITE only.
- done and err assert in the cycle after the terminating byte (or after the final write when memory is full). They are never both 1.
- in_valid without in_ready: the byte is not consumed, and the source must hold it.

## Configuration
- INSTR_LOADER_CRLF_EN
  - Defined: in SHIFT, 0x0D is accepted and discarded, but only when bit_cnt==XLEN. CRLF line endings load identically to LF.
  - Undefined: 0x0D is an illegal byte and moves the loader to ERR.

## Structure
- The shared package `instr_loader_pkg` holds:
  - the state enum typedef;
  - the ASCII constants CHAR_0, CHAR_1, CHAR_LF, CHAR_CR, CHAR_EOT;
  - the default XLEN.
- One sub-module, `ascii_bit_decoder`: combinational byte classification into is_bit, bit_val, is_lf, is_cr, is_eot, is_bad.
- The FSM, counters and shift register live in the top module.

## Test plan
- Reset, then start, then a stream of two lines "000…0001\n" and "1000…0000\n" followed by EOT. Expected:
  - a write of 0x00000001 at address 0 and 0x80000000 at address 1;
  - done=1, word_count=2.
- A line of 31 bit characters followed by '\n'. Expected: err=1, no wr_en, in_ready=0. A following start clears err and loads at address 0.
- Stream containing 'x' (0x78) mid-line. Expected: err=1 in the next cycle, with no write.
- With ADDR_W=2, stream 5 valid lines. Expected: 4 writes at addresses 0–3, then done=1, in_ready=0, and the 5th line is not consumed.
- in_valid toggled randomly while streaming 0xDEADBEEF. Expected: a single write of 0xDEADBEEF; byte order is preserved across stalls.
- "…\r\n" line endings with the macro defined. Expected: a normal write. The same stream with the macro undefined gives err=1. Asserting rst_n=0 mid-line gives all outputs at their reset values with no write.
